// File: rtl/rx_req_arbiter.sv
// rx_req_arbiter: round-robin arbitration of per-channel read requests onto one engine
// request port, with a global tag pool that routes completions back to their requester.
module rx_req_arbiter #(
    parameter int unsigned C_NUM_CHNL  = 4,
    parameter int unsigned C_TAG_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [C_NUM_CHNL-1:0]     CHNL_REQ,
    input  logic [64*C_NUM_CHNL-1:0]  CHNL_REQ_ADDR,
    input  logic [10*C_NUM_CHNL-1:0]  CHNL_REQ_LEN,
    input  logic [2*C_NUM_CHNL-1:0]   CHNL_REQ_TAG,
    output logic [C_NUM_CHNL-1:0]     CHNL_REQ_ACK,
    output logic                      ENG_REQ,
    output logic [63:0]               ENG_REQ_ADDR,
    output logic [9:0]                ENG_REQ_LEN,
    output logic [C_TAG_WIDTH-1:0]    ENG_REQ_TAG,
    input  logic                      ENG_REQ_ACK,
    input  logic                      CPL_VALID,
    input  logic [C_TAG_WIDTH-1:0]    CPL_TAG,
    input  logic                      CPL_LAST,
    output logic [C_NUM_CHNL-1:0]     CPL_CHNL,
    output logic [1:0]                CPL_LOCAL_TAG,
    output logic [C_TAG_WIDTH:0]      OUTSTANDING,
    output logic                      TAG_ERR
);

    localparam int unsigned NUM_TAGS = 2 ** C_TAG_WIDTH;
    localparam int unsigned CHNL_W   = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1;
    localparam logic [CHNL_W-1:0] LAST_CHNL = CHNL_W'(C_NUM_CHNL - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} stateT;

    stateT                  state, stateNext;
    logic [CHNL_W-1:0]      rrPtr, grantChnl, arbChnl;
    logic [1:0]             grantLocalTag;
    logic                   arbValid, freeValid, doGrant, doAlloc, cplHit, doFree;
    logic [C_TAG_WIDTH-1:0] freeTag;
    logic [NUM_TAGS-1:0]    tagAlloc;
    logic [CHNL_W-1:0]      tagChnl  [NUM_TAGS];
    logic [1:0]             tagLocal [NUM_TAGS];
    int                     arbIdx;

    // First requesting channel at or after the round-robin pointer; smallest offset wins.
    always_comb begin
        arbValid = 1'b0;
        arbChnl  = '0;
        arbIdx   = 0;
        for (int i = int'(C_NUM_CHNL) - 1; i >= 0; i--) begin
            arbIdx = int'(rrPtr) + i;
            if (arbIdx >= int'(C_NUM_CHNL)) begin
                arbIdx = arbIdx - int'(C_NUM_CHNL);
            end
            if (CHNL_REQ[CHNL_W'(arbIdx)]) begin
                arbValid = 1'b1;
                arbChnl  = CHNL_W'(arbIdx);
            end
        end
    end

    // Lowest-index free tag, from the registered allocation vector only.
    always_comb begin
        freeValid = 1'b0;
        freeTag   = '0;
        for (int t = int'(NUM_TAGS) - 1; t >= 0; t--) begin
            if (!tagAlloc[C_TAG_WIDTH'(t)]) begin
                freeValid = 1'b1;
                freeTag   = C_TAG_WIDTH'(t);
            end
        end
    end

    always_comb begin
        cplHit = CPL_VALID & tagAlloc[CPL_TAG];
        doFree = cplHit & CPL_LAST;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        doGrant      = 1'b0;
        doAlloc      = 1'b0;
        CHNL_REQ_ACK = '0;
        case (state)
            IDLE: begin
                if (arbValid && freeValid) begin
                    doGrant   = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (ENG_REQ_ACK && !RST) begin
                    doAlloc      = 1'b1;
                    CHNL_REQ_ACK = C_NUM_CHNL'(1) << grantChnl;
                    stateNext    = HOLD;
                end
            end
            HOLD:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ENG_REQ       <= 1'b0;
            ENG_REQ_ADDR  <= '0;
            ENG_REQ_LEN   <= '0;
            ENG_REQ_TAG   <= '0;
            grantChnl     <= '0;
            grantLocalTag <= '0;
            rrPtr         <= '0;
            tagAlloc      <= '0;
            OUTSTANDING   <= '0;
            CPL_CHNL      <= '0;
            CPL_LOCAL_TAG <= '0;
            TAG_ERR       <= 1'b0;
        end else begin
            if (doGrant) begin
                ENG_REQ       <= 1'b1;
                ENG_REQ_ADDR  <= 64'(CHNL_REQ_ADDR >> (64 * int'(arbChnl)));
                ENG_REQ_LEN   <= 10'(CHNL_REQ_LEN >> (10 * int'(arbChnl)));
                ENG_REQ_TAG   <= freeTag;
                grantChnl     <= arbChnl;
                grantLocalTag <= 2'(CHNL_REQ_TAG >> (2 * int'(arbChnl)));
            end
            if (doAlloc) begin
                ENG_REQ <= 1'b0;
                rrPtr   <= (grantChnl == LAST_CHNL) ? '0 : grantChnl + 1'b1;
            end
            // The tag being allocated is free, the one being freed is allocated: never the same.
            tagAlloc <= (tagAlloc | (doAlloc ? (NUM_TAGS'(1) << ENG_REQ_TAG) : '0))
                      & ~(doFree ? (NUM_TAGS'(1) << CPL_TAG) : '0);
            if (doAlloc && !doFree) begin
                OUTSTANDING <= OUTSTANDING + 1'b1;
            end else if (!doAlloc && doFree) begin
                OUTSTANDING <= OUTSTANDING - 1'b1;
            end
            CPL_CHNL <= cplHit ? (C_NUM_CHNL'(1) << tagChnl[CPL_TAG]) : '0;
            if (cplHit) begin
                CPL_LOCAL_TAG <= tagLocal[CPL_TAG];
            end
            TAG_ERR <= CPL_VALID & ~tagAlloc[CPL_TAG];
        end
    end

    // Owner table; entries are only read while their allocation bit is set.
    always_ff @(posedge CLK) begin
        if (doAlloc) begin
            tagChnl[ENG_REQ_TAG]  <= grantChnl;
            tagLocal[ENG_REQ_TAG] <= grantLocalTag;
        end
    end

endmodule

// File: tb/tb_rx_req_arbiter.sv
// Bench for rx_req_arbiter: directed vector table, corner sequences, and randomized
// traffic checked against a transaction-level model of channels and the tag pool.
module tb_rx_req_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned TW  = 5;
    localparam int unsigned NT  = 32;

    logic                 CLK;
    logic                 RST;
    logic [NCH-1:0]       CHNL_REQ;
    logic [64*NCH-1:0]    CHNL_REQ_ADDR;
    logic [10*NCH-1:0]    CHNL_REQ_LEN;
    logic [2*NCH-1:0]     CHNL_REQ_TAG;
    logic [NCH-1:0]       CHNL_REQ_ACK;
    logic                 ENG_REQ;
    logic [63:0]          ENG_REQ_ADDR;
    logic [9:0]           ENG_REQ_LEN;
    logic [TW-1:0]        ENG_REQ_TAG;
    logic                 ENG_REQ_ACK;
    logic                 CPL_VALID;
    logic [TW-1:0]        CPL_TAG;
    logic                 CPL_LAST;
    logic [NCH-1:0]       CPL_CHNL;
    logic [1:0]           CPL_LOCAL_TAG;
    logic [TW:0]          OUTSTANDING;
    logic                 TAG_ERR;

    rx_req_arbiter #(.C_NUM_CHNL(NCH), .C_TAG_WIDTH(TW)) dut (
        .CLK(CLK), .RST(RST),
        .CHNL_REQ(CHNL_REQ), .CHNL_REQ_ADDR(CHNL_REQ_ADDR), .CHNL_REQ_LEN(CHNL_REQ_LEN),
        .CHNL_REQ_TAG(CHNL_REQ_TAG), .CHNL_REQ_ACK(CHNL_REQ_ACK),
        .ENG_REQ(ENG_REQ), .ENG_REQ_ADDR(ENG_REQ_ADDR), .ENG_REQ_LEN(ENG_REQ_LEN),
        .ENG_REQ_TAG(ENG_REQ_TAG), .ENG_REQ_ACK(ENG_REQ_ACK),
        .CPL_VALID(CPL_VALID), .CPL_TAG(CPL_TAG), .CPL_LAST(CPL_LAST),
        .CPL_CHNL(CPL_CHNL), .CPL_LOCAL_TAG(CPL_LOCAL_TAG),
        .OUTSTANDING(OUTSTANDING), .TAG_ERR(TAG_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [NCH-1:0] reqV;
    logic [63:0]    chAddr [NCH];
    logic [9:0]     chLen  [NCH];
    logic [1:0]     chTag  [NCH];

    typedef struct {
        logic [3:0]  req;   logic ack;  logic cv;  logic [4:0] ct;  logic cl;
        logic        eReq;  logic [4:0] eTag;  logic [63:0] eAddr;  logic [3:0] eChAck;
        logic [5:0]  eOut;  logic [3:0] eCpl;  logic [1:0] eLoc;  logic eErr;
    } vecT;
    vecT tv [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            CHNL_REQ_ADDR[64*i +: 64] = chAddr[i];
            CHNL_REQ_LEN[10*i +: 10]  = chLen[i];
            CHNL_REQ_TAG[2*i +: 2]    = chTag[i];
        end
        CHNL_REQ = reqV;
    endtask

    task automatic setChan();
        for (int i = 0; i < NCH; i++) begin
            chAddr[i] = 64'(i) * 64'h1000;
            chLen[i]  = 10'((i + 1) * 16);
            chTag[i]  = 2'(i);
        end
    endtask

    task automatic doReset();
        cyc();
        RST = 1'b1; reqV = '0; ENG_REQ_ACK = 1'b0;
        CPL_VALID = 1'b0; CPL_TAG = '0; CPL_LAST = 1'b0;
        drive();
        cyc();
        cyc();
        RST = 1'b0;
    endtask

    function automatic int ohIdx(input logic [NCH-1:0] v);
        int r = -1;
        for (int i = 0; i < NCH; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference model state
    bit         mAlloc [NT];
    int         mOwner [NT];
    logic [1:0] mLoc   [NT];
    int         mPtr, mCh, mTag, nextArb;
    bit         mEng, mErr;
    logic [63:0] mAddr;
    logic [9:0]  mLen;
    logic [1:0]  mLocG, mLocOut;
    logic [3:0]  mCpl;

    initial begin
        RST = 1'b1; reqV = '0; ENG_REQ_ACK = 1'b0;
        CPL_VALID = 1'b0; CPL_TAG = '0; CPL_LAST = 1'b0;
        setChan();
        drive();

        // req ack cv ct cl | eReq eTag eAddr eChAck eOut eCpl eLoc eErr
        tv[0]  = '{4'b0000,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd0,4'b0000,2'd0,0};
        tv[1]  = '{4'b0010,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd0,4'b0000,2'd0,0};
        tv[2]  = '{4'b0010,0,0,5'd0,0, 1,5'd0,64'h1000,4'b0000,6'd0,4'b0000,2'd0,0};
        tv[3]  = '{4'b0010,0,0,5'd0,0, 1,5'd0,64'h1000,4'b0000,6'd0,4'b0000,2'd0,0};
        tv[4]  = '{4'b0010,1,0,5'd0,0, 1,5'd0,64'h1000,4'b0010,6'd0,4'b0000,2'd0,0};
        tv[5]  = '{4'b0000,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd1,4'b0000,2'd0,0};
        tv[6]  = '{4'b0100,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd1,4'b0000,2'd0,0};
        tv[7]  = '{4'b0100,1,0,5'd0,0, 1,5'd1,64'h2000,4'b0100,6'd1,4'b0000,2'd0,0};
        tv[8]  = '{4'b0000,0,1,5'd1,0, 0,5'd0,64'h0,   4'b0000,6'd2,4'b0000,2'd0,0};
        tv[9]  = '{4'b1000,0,1,5'd0,1, 0,5'd0,64'h0,   4'b0000,6'd2,4'b0100,2'd2,0};
        tv[10] = '{4'b1000,1,1,5'd1,1, 1,5'd2,64'h3000,4'b1000,6'd1,4'b0010,2'd1,0};
        tv[11] = '{4'b0000,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd1,4'b0100,2'd2,0};
        tv[12] = '{4'b0000,0,1,5'd0,1, 0,5'd0,64'h0,   4'b0000,6'd1,4'b0000,2'd0,0};
        tv[13] = '{4'b0000,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd1,4'b0000,2'd0,1};
        tv[14] = '{4'b0000,0,1,5'd2,1, 0,5'd0,64'h0,   4'b0000,6'd1,4'b0000,2'd0,0};
        tv[15] = '{4'b0000,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd0,4'b1000,2'd3,0};
        tv[16] = '{4'b0000,0,0,5'd0,0, 0,5'd0,64'h0,   4'b0000,6'd0,4'b0000,2'd0,0};

        doReset();
        for (int r = 0; r < 17; r++) begin
            cyc();
            reqV = tv[r].req; ENG_REQ_ACK = tv[r].ack;
            CPL_VALID = tv[r].cv; CPL_TAG = tv[r].ct; CPL_LAST = tv[r].cl;
            drive();
            #1;
            chk($sformatf("tv%0d eng_req", r), 64'(ENG_REQ), 64'(tv[r].eReq));
            if (tv[r].eReq) begin
                chk($sformatf("tv%0d eng_tag", r), 64'(ENG_REQ_TAG), 64'(tv[r].eTag));
                chk($sformatf("tv%0d eng_addr", r), ENG_REQ_ADDR, tv[r].eAddr);
            end
            chk($sformatf("tv%0d chnl_ack", r), 64'(CHNL_REQ_ACK), 64'(tv[r].eChAck));
            chk($sformatf("tv%0d outstanding", r), 64'(OUTSTANDING), 64'(tv[r].eOut));
            chk($sformatf("tv%0d cpl_chnl", r), 64'(CPL_CHNL), 64'(tv[r].eCpl));
            if (tv[r].eCpl != 0) begin
                chk($sformatf("tv%0d cpl_local", r), 64'(CPL_LOCAL_TAG), 64'(tv[r].eLoc));
            end
            chk($sformatf("tv%0d tag_err", r), 64'(TAG_ERR), 64'(tv[r].eErr));
        end
        CPL_VALID = 1'b0;

        // Fairness: all channels requesting, engine acks immediately
        begin
            int got[$];
            int tags[$];
            int when[$];
            doReset();
            reqV = 4'b1111; ENG_REQ_ACK = 1'b1;
            for (int k = 0; k < 40 && got.size() < 5; k++) begin
                cyc(); drive(); #1;
                if (CHNL_REQ_ACK != 0) begin
                    got.push_back(ohIdx(CHNL_REQ_ACK));
                    tags.push_back(int'(ENG_REQ_TAG));
                    when.push_back(k);
                end
            end
            chk("fair_grants", 64'(got.size()), 64'd5);
            for (int i = 0; i < got.size(); i++) begin
                chk($sformatf("fair_chnl%0d", i), 64'(got[i]), 64'(i % NCH));
                chk($sformatf("fair_tag%0d", i), 64'(tags[i]), 64'(i));
                if (i > 0) chk($sformatf("fair_gap%0d", i), 64'(when[i] - when[i-1]), 64'd3);
            end
        end

        // Tag exhaustion and recovery
        begin
            int nAck = 0;
            doReset();
            reqV = 4'b0001; ENG_REQ_ACK = 1'b1;
            for (int k = 0; k < 200 && nAck < 32; k++) begin
                cyc(); drive(); #1;
                if (CHNL_REQ_ACK != 0) nAck++;
            end
            chk("exh_acks", 64'(nAck), 64'd32);
            for (int k = 0; k < 5; k++) begin
                cyc(); drive(); #1;
                chk("exh_eng_idle", 64'(ENG_REQ), 64'd0);
            end
            chk("exh_outstanding", 64'(OUTSTANDING), 64'd32);
            cyc(); CPL_VALID = 1'b1; CPL_TAG = 5'd7; CPL_LAST = 1'b1; drive(); #1;
            chk("exh_free_cycle", 64'(ENG_REQ), 64'd0);
            cyc(); CPL_VALID = 1'b0; drive(); #1;
            chk("exh_arb_cycle", 64'(ENG_REQ), 64'd0);
            chk("exh_outstanding31", 64'(OUTSTANDING), 64'd31);
            cyc(); drive(); #1;
            chk("exh_reissue", 64'(ENG_REQ), 64'd1);
            chk("exh_reissue_tag", 64'(ENG_REQ_TAG), 64'd7);
            cyc(); reqV = '0; ENG_REQ_ACK = 1'b0; drive(); #1;
            chk("exh_outstanding32", 64'(OUTSTANDING), 64'd32);
        end

        // Reset while an acked request is in flight
        begin
            logic seen = 1'b0;
            doReset();
            reqV = 4'b0001; ENG_REQ_ACK = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                cyc(); drive(); #1;
                seen = ENG_REQ;
            end
            chk("rst_issue_seen", 64'(seen), 64'd1);
            RST = 1'b1; ENG_REQ_ACK = 1'b1;
            #1;
            chk("rst_issue_no_ack", 64'(CHNL_REQ_ACK), 64'd0);
            cyc(); RST = 1'b0; ENG_REQ_ACK = 1'b0; reqV = '0; drive(); #1;
            chk("rst_issue_eng_req", 64'(ENG_REQ), 64'd0);
            chk("rst_issue_outstanding", 64'(OUTSTANDING), 64'd0);
            cyc(); drive(); #1;
            chk("rst_issue_outstanding2", 64'(OUTSTANDING), 64'd0);
        end

        // Randomized traffic against the transaction model
        doReset();
        for (int t = 0; t < NT; t++) begin mAlloc[t] = 0; mOwner[t] = 0; mLoc[t] = '0; end
        mPtr = 0; mEng = 0; nextArb = 0; mCpl = '0; mErr = 0; mLocOut = '0;
        mCh = 0; mTag = 0; mAddr = '0; mLen = '0; mLocG = '0;
        for (int c = 0; c < 2000; c++) begin
            int q[$];
            int cnt, lowFree;
            bit hit;
            cyc();
            for (int i = 0; i < NCH; i++) begin
                if (!reqV[i] && $urandom_range(3) == 0) begin
                    reqV[i] = 1'b1;
                    chAddr[i] = {$urandom, $urandom};
                    chLen[i] = 10'($urandom);
                    chTag[i] = 2'($urandom);
                end
            end
            ENG_REQ_ACK = 1'($urandom_range(1));
            q = {};
            for (int t = 0; t < NT; t++) if (mAlloc[t]) q.push_back(t);
            CPL_VALID = ($urandom_range(4) < 2);
            if (q.size() > 0 && $urandom_range(9) < 8) CPL_TAG = TW'(q[$urandom_range(q.size() - 1)]);
            else CPL_TAG = TW'($urandom);
            CPL_LAST = 1'($urandom_range(1));
            drive();
            #1;
            cnt = q.size();
            chk("rnd_eng_req", 64'(ENG_REQ), 64'(mEng));
            if (mEng) begin
                chk("rnd_eng_tag", 64'(ENG_REQ_TAG), 64'(mTag));
                chk("rnd_eng_addr", ENG_REQ_ADDR, mAddr);
                chk("rnd_eng_len", 64'(ENG_REQ_LEN), 64'(mLen));
            end
            chk("rnd_chnl_ack", 64'(CHNL_REQ_ACK),
                (mEng && ENG_REQ_ACK) ? (64'd1 << mCh) : 64'd0);
            chk("rnd_outstanding", 64'(OUTSTANDING), 64'(cnt));
            chk("rnd_cpl_chnl", 64'(CPL_CHNL), 64'(mCpl));
            if (mCpl != 0) chk("rnd_cpl_local", 64'(CPL_LOCAL_TAG), 64'(mLocOut));
            chk("rnd_tag_err", 64'(TAG_ERR), 64'(mErr));

            // Advance the model across the coming edge
            hit = CPL_VALID && mAlloc[CPL_TAG];
            mCpl = hit ? (4'd1 << mOwner[CPL_TAG]) : 4'd0;
            if (hit) mLocOut = mLoc[CPL_TAG];
            mErr = CPL_VALID && !mAlloc[CPL_TAG];
            lowFree = -1;
            for (int t = NT - 1; t >= 0; t--) if (!mAlloc[t]) lowFree = t;
            if (mEng && ENG_REQ_ACK) begin
                mAlloc[mTag] = 1; mOwner[mTag] = mCh; mLoc[mTag] = mLocG;
                mPtr = (mCh + 1) % NCH;
                mEng = 0;
                nextArb = c + 2;
                reqV[mCh] = 1'b0;
            end else if (!mEng && c >= nextArb && reqV != 0 && lowFree >= 0) begin
                for (int off = NCH - 1; off >= 0; off--) begin
                    if (reqV[(mPtr + off) % NCH]) mCh = (mPtr + off) % NCH;
                end
                mEng = 1; mTag = lowFree;
                mAddr = chAddr[mCh]; mLen = chLen[mCh]; mLocG = chTag[mCh];
            end
            if (hit && CPL_LAST) mAlloc[CPL_TAG] = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
